// File: rtl/part_dec_strobe_if.sv
// rtl/part_dec_strobe_if.sv - request/enable inputs and strobe/status outputs of part_dec_strobe
interface part_dec_strobe_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic             req;
    logic [SEL_W-1:0] sel;
    logic             g1;
    logic             g2a_n;
    logic             g2b_n;
    logic             ovr_clr;
    logic [N-1:0]     y_n;
    logic             busy;
    logic             done;
    logic             ovr;

    modport master (
        output req, sel, g1, g2a_n, g2b_n, ovr_clr,
        input  y_n, busy, done, ovr
    );

    modport slave (
        input  req, sel, g1, g2a_n, g2b_n, ovr_clr,
        output y_n, busy, done, ovr
    );
endinterface

// File: rtl/part_dec_strobe.sv
// rtl/part_dec_strobe.sv - clocked 74138-style one-hot strobe decoder with hold/gap timing
// Optional one-entry pending request register: define STROBE_QUEUE_EN.
module part_dec_strobe #(
    parameter int SEL_W = 3,
    parameter int HOLD  = 1,
    parameter int GAP   = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    part_dec_strobe_if.slave bus
);
    localparam int N    = 1 << SEL_W;
    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
    localparam logic [CW-1:0] GAP_C  = CW'(GAP);

    typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [N-1:0]     y_q, y_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    logic             ovr_q, ovr_nx;
    logic             en, valid, launch, ovr_set;
    logic [SEL_W-1:0] launch_sel;
`ifdef STROBE_QUEUE_EN
    logic             pend_v, pend_v_nx;
    logic [SEL_W-1:0] pend_sel, pend_sel_nx;
`endif

    assign en    = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;
    assign valid = bus.req & en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            y_q      <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef STROBE_QUEUE_EN
            pend_v   <= 1'b0;
            pend_sel <= '0;
`endif
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            y_q      <= y_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
            ovr_q    <= ovr_nx;
`ifdef STROBE_QUEUE_EN
            pend_v   <= pend_v_nx;
            pend_sel <= pend_sel_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        y_nx       = y_q;
        busy_nx    = busy_q;
        done_nx    = 1'b0;
        ovr_set    = 1'b0;
        launch     = 1'b0;
        launch_sel = bus.sel;
`ifdef STROBE_QUEUE_EN
        pend_v_nx   = pend_v;
        pend_sel_nx = pend_sel;
`endif

        case (state)
            IDLE: begin
`ifdef STROBE_QUEUE_EN
                // A waiting strobe goes first; a concurrent request takes its slot.
                if (pend_v) begin
                    launch      = 1'b1;
                    launch_sel  = pend_sel;
                    pend_v_nx   = valid;
                    pend_sel_nx = bus.sel;
                end else
`endif
                if (valid) begin
                    launch = 1'b1;
                end
            end
            ACTIVE: begin
                if (!en || cnt == HOLD_C) begin
                    y_nx = '1;
                    if (GAP == 0) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                    end else begin
                        state_nx = RECOVER;
                        cnt_nx   = CW'(1);
                    end
`ifdef STROBE_QUEUE_EN
                    if (!en) pend_v_nx = 1'b0;
`endif
                end else begin
                    cnt_nx  = cnt + CW'(1);
                    done_nx = (cnt + CW'(1) == HOLD_C);
                end
            end
            RECOVER: begin
                if (cnt == GAP_C) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                y_nx     = '1;
                busy_nx  = 1'b0;
            end
        endcase

        if (state != IDLE && valid) begin
`ifdef STROBE_QUEUE_EN
            if (!pend_v) begin
                pend_v_nx   = 1'b1;
                pend_sel_nx = bus.sel;
            end else begin
                ovr_set = 1'b1;
            end
`else
            ovr_set = 1'b1;
`endif
        end

        if (launch) begin
            state_nx = ACTIVE;
            cnt_nx   = CW'(1);
            y_nx     = ~(N'(1) << launch_sel);
            busy_nx  = 1'b1;
            done_nx  = (HOLD == 1);
        end

        ovr_nx = ovr_set ? 1'b1 : (bus.ovr_clr ? 1'b0 : ovr_q);
    end

    assign bus.y_n  = y_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovr  = ovr_q;
endmodule

// File: tb/tb_part_dec_strobe.sv
// tb/tb_part_dec_strobe.sv - self-checking bench for part_dec_strobe over four HOLD/GAP configurations
module tb_part_dec_strobe;
`ifdef STROBE_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif
    localparam int HV[4] = '{1, 3, 4, 3};
    localparam int GV[4] = '{0, 2, 1, 0};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req = 1'b0, g1 = 1'b1, g2a_n = 1'b0, g2b_n = 1'b0, ovr_clr = 1'b0;
    logic [2:0] sel = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    part_dec_strobe_if #(.SEL_W(3)) i0 ();
    part_dec_strobe_if #(.SEL_W(3)) i1 ();
    part_dec_strobe_if #(.SEL_W(3)) i2 ();
    part_dec_strobe_if #(.SEL_W(3)) i3 ();

    assign i0.req = req;  assign i0.sel = sel;  assign i0.g1 = g1;
    assign i0.g2a_n = g2a_n;  assign i0.g2b_n = g2b_n;  assign i0.ovr_clr = ovr_clr;
    assign i1.req = req;  assign i1.sel = sel;  assign i1.g1 = g1;
    assign i1.g2a_n = g2a_n;  assign i1.g2b_n = g2b_n;  assign i1.ovr_clr = ovr_clr;
    assign i2.req = req;  assign i2.sel = sel;  assign i2.g1 = g1;
    assign i2.g2a_n = g2a_n;  assign i2.g2b_n = g2b_n;  assign i2.ovr_clr = ovr_clr;
    assign i3.req = req;  assign i3.sel = sel;  assign i3.g1 = g1;
    assign i3.g2a_n = g2a_n;  assign i3.g2b_n = g2b_n;  assign i3.ovr_clr = ovr_clr;

    part_dec_strobe #(.SEL_W(3), .HOLD(1), .GAP(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(i0));
    part_dec_strobe #(.SEL_W(3), .HOLD(3), .GAP(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(i1));
    part_dec_strobe #(.SEL_W(3), .HOLD(4), .GAP(1)) u2 (.clk(clk), .reset_n(reset_n), .bus(i2));
    part_dec_strobe #(.SEL_W(3), .HOLD(3), .GAP(0)) u3 (.clk(clk), .reset_n(reset_n), .bus(i3));

    logic [7:0] y_o[4];
    logic       busy_o[4], done_o[4], ovr_o[4];
    assign y_o[0] = i0.y_n;  assign busy_o[0] = i0.busy;  assign done_o[0] = i0.done;  assign ovr_o[0] = i0.ovr;
    assign y_o[1] = i1.y_n;  assign busy_o[1] = i1.busy;  assign done_o[1] = i1.done;  assign ovr_o[1] = i1.ovr;
    assign y_o[2] = i2.y_n;  assign busy_o[2] = i2.busy;  assign done_o[2] = i2.done;  assign ovr_o[2] = i2.ovr;
    assign y_o[3] = i3.y_n;  assign busy_o[3] = i3.busy;  assign done_o[3] = i3.done;  assign ovr_o[3] = i3.ovr;

    // Reference model: each strobe is described by timestamps (cycle numbers), not states.
    int cyc;
    int low_until[4], busy_until[4], done_cyc[4], cur_sel[4];
    int pend_q[4][$];
    bit m_ovr[4];

    function automatic void model_reset();
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            low_until[k] = 0; busy_until[k] = 0; done_cyc[k] = -1; cur_sel[k] = 0;
            pend_q[k].delete(); m_ovr[k] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit en, valid, ovr_set;
        int launch;
        en    = g1 && !g2a_n && !g2b_n;
        valid = req && en;
        for (int k = 0; k < 4; k++) begin
            ovr_set = 1'b0;
            launch  = -1;
            if (cyc < low_until[k] && !en) begin
                low_until[k]  = cyc + 1;
                busy_until[k] = cyc + 1 + GV[k];
                done_cyc[k]   = -1;
                pend_q[k].delete();
            end else if (cyc >= busy_until[k]) begin
                if (pend_q[k].size() > 0) begin
                    launch = pend_q[k].pop_front();
                    if (valid) pend_q[k].push_back(int'(sel));
                end else if (valid) begin
                    launch = int'(sel);
                end
            end else if (valid) begin
                if (QUEUE && pend_q[k].size() == 0) pend_q[k].push_back(int'(sel));
                else ovr_set = 1'b1;
            end
            if (launch >= 0) begin
                cur_sel[k]    = launch;
                low_until[k]  = cyc + 1 + HV[k];
                busy_until[k] = cyc + 1 + HV[k] + GV[k];
                done_cyc[k]   = cyc + HV[k];
            end
            if (ovr_set) m_ovr[k] = 1'b1;
            else if (ovr_clr) m_ovr[k] = 1'b0;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req = 1'b0; sel = '0; g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (y_o[k] !== 8'hff || busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || ovr_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: got y=%h busy=%b done=%b ovr=%b, expected y=ff busy=0 done=0 ovr=0",
                         k, y_o[k], busy_o[k], done_o[k], ovr_o[k]);
            end
        end
    endtask

    task automatic test_basic_strobe();
        apply_reset();
        req = 1'b1; sel = 3'd5;
        tick();
        req = 1'b0;
        checks++;
        if (y_o[0] !== 8'b1101_1111 || done_o[0] !== 1'b1 || busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_c1: got y=%h done=%b busy=%b, expected y=df done=1 busy=1", y_o[0], done_o[0], busy_o[0]);
        end
        tick();
        checks++;
        if (y_o[0] !== 8'hff || done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_c2: got y=%h done=%b busy=%b, expected y=ff done=0 busy=0", y_o[0], done_o[0], busy_o[0]);
        end
    endtask

    task automatic test_hold_gap();
        logic [7:0] ey;
        logic eb, ed;
        apply_reset();
        req = 1'b1; sel = 3'd0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            req = 1'b0;
            sel = 3'($urandom_range(0, 7));
            ey = (c <= 3) ? 8'hfe : 8'hff;
            eb = (c <= 5);
            ed = (c == 3);
            checks++;
            if (y_o[1] !== ey || busy_o[1] !== eb || done_o[1] !== ed) begin
                errors++;
                $display("FAIL hold_gap_c%0d: got y=%h busy=%b done=%b, expected y=%h busy=%b done=%b",
                         c, y_o[1], busy_o[1], done_o[1], ey, eb, ed);
            end
        end
    endtask

    task automatic test_enables();
        for (int m = 0; m < 3; m++) begin
            apply_reset();
            g1 = (m != 0); g2a_n = (m == 1); g2b_n = (m == 2);
            req = 1'b1; sel = 3'($urandom_range(0, 7));
            tick();
            tick();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (y_o[k] !== 8'hff || busy_o[k] !== 1'b0 || ovr_o[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL enables_m%0d_inst%0d: got y=%h busy=%b ovr=%b, expected y=ff busy=0 ovr=0",
                             m, k, y_o[k], busy_o[k], ovr_o[k]);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic done_seen;
        apply_reset();
        done_seen = 1'b0;
        req = 1'b1; sel = 3'd3;
        tick();
        req = 1'b0;
        done_seen |= done_o[2];
        tick();
        done_seen |= done_o[2];
        g1 = 1'b0;
        tick();
        done_seen |= done_o[2];
        checks++;
        if (y_o[2] !== 8'hff || busy_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort_c3: got y=%h busy=%b, expected y=ff busy=1", y_o[2], busy_o[2]);
        end
        tick();
        done_seen |= done_o[2];
        g1 = 1'b1;
        checks++;
        if (busy_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_c4: got busy=%b, expected busy=0", busy_o[2]);
        end
        tick();
        done_seen |= done_o[2];
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: got done pulse=%b, expected 0", done_seen);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] ey;
        apply_reset();
        req = 1'b1; sel = 3'd1;
        tick();
        sel = 3'd2;
        tick();
        req = 1'b0;
        checks++;
        if (ovr_o[3] !== !QUEUE) begin
            errors++;
            $display("FAIL overrun_ovr: got ovr=%b, expected %b", ovr_o[3], !QUEUE);
        end
        for (int c = 3; c <= 9; c++) begin
            tick();
            if (c <= 3) ey = 8'hfd;
            else if (QUEUE && c >= 5 && c <= 7) ey = 8'hfb;
            else ey = 8'hff;
            checks++;
            if (y_o[3] !== ey) begin
                errors++;
                $display("FAIL overrun_y_c%0d: got y=%h, expected y=%h", c, y_o[3], ey);
            end
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++;
        if (ovr_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr: got ovr=%b, expected 0", ovr_o[3]);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 1'b1; sel = 3'd0;
        tick();
        req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (y_o[1] !== 8'hff || busy_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got y=%h busy=%b, expected y=ff busy=0", y_o[1], busy_o[1]);
        end
        reset_n = 1'b1;
        model_reset();
        req = 1'b1; sel = 3'd5;
        tick();
        req = 1'b0;
        checks++;
        if (y_o[0] !== 8'hdf || done_o[0] !== 1'b1 || busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_c1: got y=%h done=%b busy=%b, expected y=df done=1 busy=1", y_o[0], done_o[0], busy_o[0]);
        end
        tick();
        checks++;
        if (y_o[0] !== 8'hff || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_c2: got y=%h busy=%b, expected y=ff busy=0", y_o[0], busy_o[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] ey;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            req     = ($urandom_range(0, 1) == 1);
            sel     = 3'($urandom_range(0, 7));
            g1      = ($urandom_range(0, 15) != 0);
            g2a_n   = ($urandom_range(0, 19) == 0);
            g2b_n   = ($urandom_range(0, 19) == 0);
            ovr_clr = ($urandom_range(0, 24) == 0);
            tick();
            for (int k = 0; k < 4; k++) begin
                ey = (cyc < low_until[k]) ? ~(8'd1 << cur_sel[k]) : 8'hff;
                checks++;
                if (y_o[k] !== ey || busy_o[k] !== (cyc < busy_until[k]) ||
                    done_o[k] !== (cyc == done_cyc[k]) || ovr_o[k] !== m_ovr[k]) begin
                    errors++;
                    $display("FAIL random_inst%0d_cyc%0d: got y=%h busy=%b done=%b ovr=%b, expected y=%h busy=%b done=%b ovr=%b",
                             k, cyc, y_o[k], busy_o[k], done_o[k], ovr_o[k],
                             ey, (cyc < busy_until[k]), (cyc == done_cyc[k]), m_ovr[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_strobe();
        test_hold_gap();
        test_enables();
        test_abort();
        test_overrun();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
